// File: rtl/branch_checkpoint_stack_pkg.sv
// branch_checkpoint_stack_pkg: shared sizes, tag type and zero-register constants
package branch_checkpoint_stack_pkg;
  localparam int NUM_BR = 4;
  localparam int HEAD_W = 5;
  typedef logic [1:0] br_tag_t;
  localparam logic [HEAD_W-1:0] ZERO_REG = '0;
  localparam logic [HEAD_W-1:0] ZERO_HEAD = '0;
endpackage

// File: rtl/branch_checkpoint_stack_br_free_select.sv
// br_free_select: finds the lowest and second-lowest set bits of a free vector
module br_free_select #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] free_i,
  output logic [W-1:0] first_o,
  output logic         first_vld_o,
  output logic [W-1:0] second_o,
  output logic         second_vld_o
);
  // scan downwards so the last hit is the lowest and the previous hit the next-lowest
  always_comb begin
    first_o = '0;
    first_vld_o = 1'b0;
    second_o = '0;
    second_vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        second_o = first_o;
        second_vld_o = first_vld_o;
        first_o = W'(i);
        first_vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/branch_checkpoint_stack.sv
// branch_checkpoint_stack: per-branch freelist-head checkpoints with mispredict recovery
module branch_checkpoint_stack #(
  parameter int NUM_BR = branch_checkpoint_stack_pkg::NUM_BR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid_IRA,
  input  logic              id_valid_IRB,
  input  logic              id_branchA,
  input  logic              id_branchB,
  input  logic              id_allocA,
  input  logic [4:0]        fl_head,
  input  logic              ex_br_resolve_en,
  input  logic [1:0]        ex_br_tag,
  input  logic              ex_br_mispredict,
  output logic [1:0]        br_tagA,
  output logic [1:0]        br_tagB,
  output logic [NUM_BR-1:0] br_mask,
  output logic              br_stall,
  output logic              branch_recovery_en,
  output logic [4:0]        branch_recovery_head,
  output logic [NUM_BR-1:0] br_squash_mask
);
  import branch_checkpoint_stack_pkg::*;
  logic [NUM_BR-1:0] valid_q, valid_d;
  logic [4:0]        head_q [NUM_BR];
  logic [4:0]        head_d [NUM_BR];
  logic [NUM_BR-1:0] older_q [NUM_BR];
  logic [NUM_BR-1:0] older_d [NUM_BR];
  logic              rec_en_q, rec_en_d;
  logic [4:0]        rec_head_q, rec_head_d;
  logic [NUM_BR-1:0] squash_q, squash_d;
  br_tag_t           first, second;
  logic              first_vld, second_vld;
  logic              req_a, req_b, res_v, mis, ok, alloc;
  logic [NUM_BR-1:0] res_oh, oh_a, kill, base;
  logic [4:0]        head_b;
  br_free_select #(.N(NUM_BR)) u_sel (
    .free_i      (~valid_q),
    .first_o     (first),
    .first_vld_o (first_vld),
    .second_o    (second),
    .second_vld_o(second_vld)
  );
  assign req_a   = id_valid_IRA & id_branchA;
  assign req_b   = id_valid_IRA & id_valid_IRB & id_branchB;
  assign res_v   = ex_br_resolve_en & valid_q[ex_br_tag];
  assign mis     = res_v & ex_br_mispredict;
  assign ok      = res_v & ~ex_br_mispredict;
  assign res_oh  = NUM_BR'(1) << ex_br_tag;
  assign br_tagA = first;
  assign br_tagB = req_a ? second : first;
  assign oh_a    = NUM_BR'(1) << br_tagA;
  assign br_stall = ((req_a | req_b) & ~first_vld) | (req_a & req_b & ~second_vld);
  assign alloc   = ~br_stall & ~mis;
  assign head_b  = id_allocA ? fl_head + 5'd1 : fl_head;
  assign base    = valid_q & ~(ok ? res_oh : '0);
  assign br_mask = valid_q;
  assign branch_recovery_en   = rec_en_q;
  assign branch_recovery_head = rec_head_q;
  assign br_squash_mask       = squash_q;
  // the mispredicted entry plus every live entry younger than it
  always_comb begin
    kill = res_oh;
    for (int i = 0; i < NUM_BR; i++) kill[i] = kill[i] | older_q[i][ex_br_tag];
    kill = kill & valid_q;
  end
  // next checkpoint state: resolve first, then same-cycle allocation of A then B
  always_comb begin
    head_d = head_q;
    for (int i = 0; i < NUM_BR; i++) older_d[i] = older_q[i] & ~(ok ? res_oh : '0);
    valid_d = mis ? valid_q & ~kill : base;
    if (alloc && req_a) begin
      valid_d[br_tagA] = 1'b1;
      head_d[br_tagA] = fl_head;
      older_d[br_tagA] = base;
    end
    if (alloc && req_b) begin
      valid_d[br_tagB] = 1'b1;
      head_d[br_tagB] = head_b;
      older_d[br_tagB] = base | (req_a ? oh_a : '0);
    end
    rec_en_d = mis;
    rec_head_d = mis ? head_q[ex_br_tag] : ZERO_REG;
    squash_d = mis ? kill : '0;
  end
  // state registers with reset overriding dispatch, resolve and pending recovery
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_BR; i++) begin
        head_q[i] <= ZERO_HEAD;
        older_q[i] <= '0;
      end
      rec_en_q <= 1'b0;
      rec_head_q <= ZERO_REG;
      squash_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q <= head_d;
      older_q <= older_d;
      rec_en_q <= rec_en_d;
      rec_head_q <= rec_head_d;
      squash_q <= squash_d;
    end
  end
endmodule

// File: doc/branch_checkpoint_stack.md
BRANCH_CHECKPOINT_STACK -- requirements
Module: branch_checkpoint_stack

Interface
REQ-001 Parameter NUM_BR, default 4: number of checkpoint entries, which is also the branch-mask width.
REQ-002 clock  in  1  system clock; reset  in  1  synchronous, active-high reset.
REQ-003 id_valid_IRA, id_valid_IRB  in  1 each  dispatch slot valid; B valid only when A valid.
REQ-004 id_branchA, id_branchB  in  1 each  slot holds a conditional branch (branches never allocate a physical register).
REQ-005 id_allocA  in  1  slot A takes a freelist tag (valid, dest not zero register).
REQ-006 fl_head  in  5  current freelist head pointer.
REQ-007 ex_br_resolve_en  in  1; ex_br_tag  in  2; ex_br_mispredict  in  1  branch resolution from execute.
REQ-008 br_tagA, br_tagB  out  2 each  checkpoint index assigned to the branch in slot A/B.
REQ-009 br_mask  out  NUM_BR  live-branch mask to tag dispatched instructions.
REQ-010 br_stall  out  1  insufficient free entries for this cycle's branches.
REQ-011 branch_recovery_en  out  1; branch_recovery_head  out  5  freelist head restore.
REQ-012 br_squash_mask  out  NUM_BR  entries killed by a mispredict.

Function
REQ-013 Each entry SHALL hold: valid, 5-bit saved head, NUM_BR-bit older-mask (live branches older than it).
REQ-014 Branch in A SHALL checkpoint fl_head; branch in B SHALL checkpoint fl_head+1 (mod 32) if id_allocA, else fl_head.
REQ-015 br_tagA SHALL be the lowest-index invalid entry; br_tagB SHALL be the next-lowest invalid entry if A is a branch, else the lowest.
REQ-016 br_stall SHALL be asserted combinationally when the number of requesting branches exceeds the number of invalid entries; no entry SHALL be allocated in a stalled cycle.
REQ-017 The older-mask of a new entry SHALL be br_mask, minus the bit of any branch resolved correct this cycle; B's older-mask SHALL also include A's bit when A is a branch.
REQ-018 A correct resolve SHALL clear the entry's valid bit and clear that bit in every entry's older-mask at the next edge.
REQ-019 A mispredict resolve SHALL invalidate the entry and every entry whose older-mask contains its bit, and SHALL discard the same-cycle allocation.
REQ-020 The mispredict SHALL set, one cycle later for exactly one cycle: branch_recovery_en=1, branch_recovery_head = the entry's saved head, br_squash_mask = the invalidated set including the entry.
REQ-021 br_mask SHALL equal the registered valid vector.
REQ-022 A resolve on an invalid tag SHALL be ignored.
REQ-023 Index and head arithmetic SHALL wrap modulo 4 and modulo 32 respectively.

Reset
REQ-024 Reset SHALL clear all valid bits and older-masks and zero the saved heads; it SHALL drive branch_recovery_en=0, branch_recovery_head=0 and br_squash_mask=0 on the next cycle.
REQ-025 Reset SHALL take priority over same-cycle dispatch and resolve; a pending recovery SHALL be dropped.

Structure
REQ-026 NUM_BR, the 2-bit tag type and the zero-register constants SHALL live in the shared defines package.
REQ-027 One sub-module, br_free_select (two-lowest-free priority encoder), SHALL be instantiated.

Verification
REQ-028 Reset, then a branch in A with fl_head=5 -> br_tagA=0; next cycle br_mask=0001.
REQ-029 A alloc + B branch, fl_head=31 -> entry saves head 0 (wrap).
REQ-030 Allocate tags 0,1,2 in order, then mispredict tag 0 (saved head 7) -> one cycle later branch_recovery_en=1, branch_recovery_head=7, br_squash_mask=0111, br_mask=0000.
REQ-031 Allocate tags 0,1, then resolve 0 correct while B is a new branch -> new entry's older-mask=0010; tag 0 reused on the next allocation.
REQ-032 All 4 entries valid, two branches dispatched -> br_stall=1, no state change.
REQ-033 Assert reset in the cycle after a mispredict -> branch_recovery_en=0 and all state cleared.
